// File: rtl/simple_axi_pkg.sv
// Shared AXI definitions used by the single-beat master and the RAM slave.
// Contents: response codes, burst encodings, read/write op codes, the slave
// FSM state type and a burst-support helper.
package simple_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } rw_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_DATA,
    ST_W_DELAY,
    ST_W_RESP,
    ST_R_READ,
    ST_R_DELAY,
    ST_R_RESP
  } slv_state_t;

  // Single-beat INCR and WRAP are equivalent; FIXED and the reserved code are refused.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_INCR) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/simple_ram_sp.sv
// Single-port synchronous RAM, DEPTH x DATA_WIDTH, per-byte write enable,
// registered read data (1-cycle latency). Contents are never cleared.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_be     byte enables (one per data byte)
//   i_addr   word index
//   i_wdata  write data
//   o_rdata  read data for the address presented on the previous edge
module simple_ram_sp #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [DATA_WIDTH/8-1:0]  i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/simple_axi_slave_ram.sv
// Single-beat AXI4 slave backed by an on-chip word-addressed RAM.
// One transaction at a time, writes win over simultaneous reads, requests
// outside the base/depth window get DECERR, unsupported ones SLVERR.
// RESP_DELAY inserts extra cycles before bvalid/rvalid.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   s_axi_aw*               write address channel
//   s_axi_w*                write data channel
//   s_axi_b*                write response channel
//   s_axi_ar*               read address channel
//   s_axi_r*                read data channel
//
// state      | meaning
// IDLE       | ready for AW (priority) or AR
// W_DATA     | address latched, waiting for the W beat
// W_DELAY    | counting down RESP_DELAY before the write response
// W_RESP     | bvalid high until bready
// R_READ     | RAM read in flight, capture rdata/rresp at exit
// R_DELAY    | counting down RESP_DELAY before the read response
// R_RESP     | rvalid/rlast high until rready
module simple_axi_slave_ram
  import simple_axi_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RESP_DELAY = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);

  localparam int         LSB      = $clog2(DATA_WIDTH / 8);
  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [3:0] DLY_LOAD = (RESP_DELAY > 0) ? 4'(RESP_DELAY - 1) : 4'd0;

  slv_state_t            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [3:0]            r_dly_cnt;
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [ADDR_WIDTH-1:0] w_dec_addr;
  logic [ADDR_WIDTH:0]   w_diff;
  logic                  w_decerr, w_attr_err;
  logic [1:0]            w_wr_resp, w_rd_resp;
  logic                  w_ram_we;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // In IDLE the RAM is already addressed from araddr so the word is ready
  // during R_READ; elsewhere the latched address drives decode and RAM.
  assign w_dec_addr = (r_state == ST_IDLE) ? s_axi_araddr : r_addr;
  // The extra MSB is the borrow, i.e. address below the window base.
  assign w_diff     = {1'b0, w_dec_addr} - {1'b0, BASE_ADDR};
  assign w_decerr   = w_diff[ADDR_WIDTH] || (w_diff[ADDR_WIDTH-1:LSB+IDX_W] != '0);
  assign w_attr_err = (r_len != 8'd0) || (r_size != 3'(LSB)) || !burst_supported(r_burst)
                      || (w_diff[LSB-1:0] != '0);
  assign w_rd_resp  = w_decerr ? RESP_DECERR : (w_attr_err ? RESP_SLVERR : RESP_OKAY);
  assign w_wr_resp  = w_decerr ? RESP_DECERR :
                      ((w_attr_err || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY);
  assign w_ram_we   = (r_state == ST_W_DATA) && s_axi_wvalid && (w_wr_resp == RESP_OKAY);

  simple_ram_sp #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_be    (s_axi_wstrb),
    .i_addr  (w_diff[LSB+IDX_W-1:LSB]),
    .i_wdata (s_axi_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (s_axi_awvalid)      w_state_nxt = ST_W_DATA;
        else if (s_axi_arvalid) w_state_nxt = ST_R_READ;
      end
      ST_W_DATA:  if (s_axi_wvalid) w_state_nxt = (RESP_DELAY > 0) ? ST_W_DELAY : ST_W_RESP;
      ST_W_DELAY: if (r_dly_cnt == 4'd0) w_state_nxt = ST_W_RESP;
      ST_W_RESP:  if (s_axi_bready) w_state_nxt = ST_IDLE;
      ST_R_READ:  w_state_nxt = (RESP_DELAY > 0) ? ST_R_DELAY : ST_R_RESP;
      ST_R_DELAY: if (r_dly_cnt == 4'd0) w_state_nxt = ST_R_RESP;
      ST_R_RESP:  if (s_axi_rready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_dly_cnt <= '0;
      r_bresp   <= RESP_OKAY;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (s_axi_awvalid) begin
            r_addr  <= s_axi_awaddr;
            r_len   <= s_axi_awlen;
            r_size  <= s_axi_awsize;
            r_burst <= s_axi_awburst;
          end else if (s_axi_arvalid) begin
            r_addr  <= s_axi_araddr;
            r_len   <= s_axi_arlen;
            r_size  <= s_axi_arsize;
            r_burst <= s_axi_arburst;
          end
        end
        ST_W_DATA: begin
          if (s_axi_wvalid) begin
            r_bresp   <= w_wr_resp;
            r_dly_cnt <= DLY_LOAD;
          end
        end
        ST_R_READ: begin
          r_rresp   <= w_rd_resp;
          r_rdata   <= (w_rd_resp == RESP_OKAY) ? w_ram_rdata : '0;
          r_dly_cnt <= DLY_LOAD;
        end
        ST_W_DELAY, ST_R_DELAY: r_dly_cnt <= r_dly_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  assign s_axi_awready = i_rst_n && (r_state == ST_IDLE);
  assign s_axi_arready = i_rst_n && (r_state == ST_IDLE) && !s_axi_awvalid;
  assign s_axi_wready  = i_rst_n && (r_state == ST_W_DATA);
  assign s_axi_bvalid  = (r_state == ST_W_RESP);
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = (r_state == ST_R_RESP);
  assign s_axi_rlast   = (r_state == ST_R_RESP);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

endmodule

// File: doc/simple_axi_slave_ram.md
# simple_axi_slave_ram

AXI4 slave that sits directly downstream of the single-beat AXI master and services its AW/W/B and AR/R channels from an on-chip word-addressed RAM. It accepts one transaction at a time and decodes addresses against a base/depth window. Unsupported requests get SLVERR and out-of-window requests get DECERR. A programmable response delay lets benches exercise the master's wait states.

## Interface
- DATA_WIDTH, 32, data bus width in bits (multiple of 8, ≥16)
- ADDR_WIDTH, 32, address bus width
- MEM_DEPTH, 1024, RAM depth in words (power of two)
- BASE_ADDR, 0, byte address of word 0 (aligned to MEM_DEPTH*DATA_WIDTH/8)
- RESP_DELAY, 0, extra cycles (0–15) inserted before bvalid/rvalid
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset; one clock, reset asynchronous and active-low
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
- s_axi_awaddr  in  ADDR_WIDTH  write byte address
- s_axi_awlen  in  8;  s_axi_awsize  in  3;  s_axi_awburst  in  2  write attributes
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake
- s_axi_wdata  in  DATA_WIDTH;  s_axi_wstrb  in  DATA_WIDTH/8;  s_axi_wlast  in  1
- s_axi_bvalid / s_axi_bready  out/in  1;  s_axi_bresp  out  2  write response
- s_axi_arvalid / s_axi_arready  in/out  1;  s_axi_araddr  in  ADDR_WIDTH
- s_axi_arlen  in  8;  s_axi_arsize  in  3;  s_axi_arburst  in  2  read attributes
- s_axi_rvalid / s_axi_rready  out/in  1;  s_axi_rdata  out  DATA_WIDTH;  s_axi_rresp  out  2;  s_axi_rlast  out  1

## Operation
- FSM states: IDLE, W_DATA, W_DELAY, W_RESP, R_READ, R_DELAY, R_RESP.
- Ready signals are decoded from the state and forced low while i_rst_n=0:
  - awready = IDLE
  - arready = IDLE & !awvalid (write has priority on simultaneous requests)
  - wready = W_DATA
- IDLE:
  - On an AW handshake, latch addr/len/size/burst and go to W_DATA.
  - On an AR handshake, latch the same and go to R_READ.
  - A W beat arriving before AW waits, because wready is low.
- Checks, evaluated on the latched request plus wlast. DECERR takes priority over SLVERR.
  - DECERR: addr < BASE_ADDR, or word index ≥ MEM_DEPTH.
  - SLVERR: len≠0, size≠log2(DATA_WIDTH/8), burst=FIXED/reserved (3), misaligned low address bits, or wlast=0 on the write beat.
- W_DATA:
  - On a W handshake, write the RAM with byte enables = wstrb, only if the response is OKAY.
  - Register bresp.
  - Go to W_DELAY if RESP_DELAY>0 (counter loaded with RESP_DELAY-1), else W_RESP.
- R_READ: present the word index to the RAM for one cycle. Then register rdata (0 on error) and rresp, and go to R_DELAY or R_RESP.
- W_DELAY / R_DELAY: a 4-bit counter decrements each cycle; at 0, advance to the *_RESP state.
- W_RESP: bvalid=1 with bresp stable until bready, then IDLE.
- R_RESP: rvalid=1 and rlast=1, with rdata/rresp stable until rready, then IDLE.
- Reset values:
  - state IDLE; bvalid, rvalid and rlast 0; bresp and rresp 00; rdata 0; all ready signals 0.
  - RAM contents are not cleared.
- Reset mid-transaction aborts it and the pending response is dropped. A RAM write already performed stays.

## Timing
- Write: AW handshake at edge E0 → wready high from cycle E0+1.
  - W handshake at edge E1 → RAM written at E1.
  - bvalid is high from E1+1+RESP_DELAY.
- Read: AR handshake at edge E0 → rvalid is high from E0+2+RESP_DELAY.
- Back-to-back: awready/arready return the cycle after the B/R handshake. Minimum turnaround is 1 idle cycle.
- Valid outputs never drop without a handshake. Response payloads never change while valid is high.

## Structure
- Shared package simple_axi_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_FIXED/INCR/WRAP, RW op codes. The master migrates to the same package.
- Sub-module simple_ram_sp: single-port synchronous RAM, DEPTH × DATA_WIDTH, per-byte write enable, 1-cycle read latency.
- FSM, decode and delay counter live in the top module.

## Test plan
- Write 0xDEADBEEF to 0x10 with wstrb=F, then read 0x10 → bresp=OKAY, rdata=0xDEADBEEF, rresp=OKAY, rlast=1.
  - Check bvalid at E1+1 and rvalid at E0+2 for RESP_DELAY=0.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD with wstrb=0101, then read → 0x11BB33DD.
- Read BASE_ADDR+MEM_DEPTH*4 → rresp=DECERR, rdata=0. Write the same address → bresp=DECERR and the RAM is unchanged.
- Each of the following → SLVERR, and no RAM update on the writes:
  - write with awlen=1
  - read at 0x22 (misaligned)
  - write with wlast=0
- RESP_DELAY=5, plus bready/rready held low 3 cycles → bvalid/rvalid rise exactly 5 cycles later and stay stable until the handshake.
- AW and AR valid in the same cycle → write completes first; AR is accepted in the first IDLE cycle after the B handshake.
- Assert i_rst_n low in W_RESP → bvalid drops immediately; after release awready=1 and the RAM holds the written data.
